// File: rtl/spram_bank_ctrl.sv
// Depth-cascaded controller for 1..4 16x16K single-port RAM banks with a
// valid/ready request port, fixed-latency reads and a full zero-fill sweep.
module spram_bank_ctrl #(
  parameter int NBANKS         = 2,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDRW         = 14 + $clog2(NBANKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_be,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [15:0]      req_wdata,
  input  logic             clear_req,
  output logic             busy,
  output logic             rd_valid,
  output logic [15:0]      rd_data,
  output logic             oor
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state, w_state_nxt;
  logic [13:0]         r_clr_addr, w_clr_addr_nxt;
  logic                w_accept;
  logic                w_oor;
  logic [2:0]          w_bank;
  logic [NBANKS-1:0]   w_we;
  logic [1:0]          w_mask;
  logic [15:0]         w_din;
  logic [13:0]         w_addr;
  logic [15:0]         r_mem  [NBANKS][16384];
  logic [15:0]         r_dout [NBANKS];
  logic                r_p1_valid;
  logic [2:0]          r_p1_bank;
  logic                r_oor;
  logic [15:0]         w_mux;

  // Padding keeps the bank-select extraction legal when NBANKS=1 (no bank bits).
  assign w_bank = 3'({3'b000, req_addr} >> 14);
  assign w_oor  = int'(w_bank) >= NBANKS;
  assign oor    = r_oor;

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = '0;
    w_mask         = req_be;
    w_din          = req_wdata;
    w_addr         = req_addr[13:0];
    req_ready      = (r_state == ST_IDLE) && !reset;
    busy           = (r_state == ST_CLEAR);
    w_accept       = req_valid && req_ready;
    case (r_state)
      ST_CLEAR: begin
        w_we           = {NBANKS{!reset}};
        w_mask         = 2'b11;
        w_din          = '0;
        w_addr         = r_clr_addr;
        w_clr_addr_nxt = r_clr_addr + 14'd1;
        if (r_clr_addr == '1) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (w_accept && req_we && !w_oor) begin
          for (int unsigned b = 0; b < NBANKS; b++) begin
            if (w_bank == 3'(b)) w_we[b] = |req_be;
          end
        end
        if (clear_req && !reset) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Banks: byte-masked write, otherwise registered read of the shared address.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (w_we[b]) begin
        if (w_mask[0]) r_mem[b][w_addr][7:0]  <= w_din[7:0];
        if (w_mask[1]) r_mem[b][w_addr][15:8] <= w_din[15:8];
      end else begin
        r_dout[b] <= r_mem[b][w_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_valid <= 1'b0;
      r_p1_bank  <= '0;
      r_oor      <= 1'b0;
    end else begin
      r_p1_valid <= w_accept && !req_we;
      r_p1_bank  <= w_bank;
      r_oor      <= w_accept && w_oor;
    end
  end

  // An out-of-range bank index matches no bank and reads back as zero.
  always_comb begin
    w_mux = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (r_p1_bank == 3'(b)) w_mux = r_dout[b];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic        r_rd_valid;
      logic [15:0] r_rd_data;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= r_p1_valid;
          if (r_p1_valid) r_rd_data <= w_mux;
        end
      end
      assign rd_valid = r_rd_valid;
      assign rd_data  = r_rd_data;
    end else begin : g_noreg
      // Bank outputs move on every idle cycle, so the last result is held here.
      logic [15:0] r_hold;
      always_ff @(posedge clk) begin
        if (reset)           r_hold <= '0;
        else if (r_p1_valid) r_hold <= w_mux;
      end
      assign rd_valid = r_p1_valid;
      assign rd_data  = r_p1_valid ? w_mux : r_hold;
    end
  endgenerate

endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Bench for spram_bank_ctrl: a 2-bank registered-output instance with clear on
// reset, and a 3-bank unregistered instance for out-of-range bank behaviour.
module tb_spram_bank_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic a_reset, a_req_valid, a_req_ready, a_req_we, a_clear_req, a_busy, a_rd_valid, a_oor;
  logic [1:0] a_req_be;
  logic [14:0] a_req_addr;
  logic [15:0] a_req_wdata, a_rd_data;
  logic b_reset, b_req_valid, b_req_ready, b_req_we, b_clear_req, b_busy, b_rd_valid, b_oor;
  logic [1:0] b_req_be;
  logic [15:0] b_req_addr;
  logic [15:0] b_req_wdata, b_rd_data;

  spram_bank_ctrl #(.NBANKS(2), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .clear_req(a_clear_req), .busy(a_busy), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .oor(a_oor));

  spram_bank_ctrl #(.NBANKS(3), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .clear_req(b_clear_req), .busy(b_busy), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .oor(b_oor));

  // Reference contents of the 2-bank instance (32K words).
  logic [15:0] ma [32768];

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    merge = old;
    if (be[0]) merge[7:0]  = d[7:0];
    if (be[1]) merge[15:8] = d[15:8];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32768; i++) ma[i] = 16'h0000;
  endtask

  task automatic a_drive(input logic we, input logic [1:0] be, input logic [14:0] addr,
                         input logic [15:0] d);
    a_req_valid = 1'b1; a_req_we = we; a_req_be = be; a_req_addr = addr; a_req_wdata = d;
    if (we) ma[addr] = merge(ma[addr], d, be);
  endtask

  task automatic b_drive(input logic we, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] d);
    b_req_valid = 1'b1; b_req_we = we; b_req_be = be; b_req_addr = addr; b_req_wdata = d;
  endtask

  task automatic test_oor();
    b_reset = 1'b1; tick(); tick();
    checks += 4;
    if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL b_rst_rd_valid got %b exp 0", b_rd_valid); end
    if (b_rd_data !== 16'h0) begin errors++; $display("FAIL b_rst_rd_data got %h exp 0000", b_rd_data); end
    if (b_oor !== 1'b0) begin errors++; $display("FAIL b_rst_oor got %b exp 0", b_oor); end
    if (b_req_ready !== 1'b0) begin errors++; $display("FAIL b_rst_ready got %b exp 0", b_req_ready); end
    b_reset = 1'b0; #1;
    checks += 2;
    if (b_req_ready !== 1'b1) begin errors++; $display("FAIL b_ready_after_reset got %b exp 1", b_req_ready); end
    if (b_busy !== 1'b0) begin errors++; $display("FAIL b_busy_after_reset got %b exp 0", b_busy); end
    b_drive(1'b1, 2'b11, 16'h8000, 16'h1111); tick();
    checks++;
    if (b_oor !== 1'b0) begin errors++; $display("FAIL b_oor_inrange got %b exp 0", b_oor); end
    b_drive(1'b1, 2'b11, 16'hC000, 16'hBEEF); tick();
    checks += 2;
    if (b_oor !== 1'b1) begin errors++; $display("FAIL b_oor_write got %b exp 1", b_oor); end
    if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL b_write_no_rd_valid got %b exp 0", b_rd_valid); end
    b_drive(1'b0, 2'b00, 16'hC000, 16'h0000); tick();
    checks += 3;
    if (b_oor !== 1'b1) begin errors++; $display("FAIL b_oor_read got %b exp 1", b_oor); end
    if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL b_oor_rd_valid got %b exp 1", b_rd_valid); end
    if (b_rd_data !== 16'h0000) begin errors++; $display("FAIL b_oor_rd_data got %h exp 0000", b_rd_data); end
    b_drive(1'b0, 2'b00, 16'h8000, 16'h0000); tick();
    checks += 3;
    if (b_oor !== 1'b0) begin errors++; $display("FAIL b_oor_clear got %b exp 0", b_oor); end
    if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL b_bank2_rd_valid got %b exp 1", b_rd_valid); end
    if (b_rd_data !== 16'h1111) begin errors++; $display("FAIL b_bank2_rd_data got %h exp 1111", b_rd_data); end
    b_req_valid = 1'b0; tick();
    checks += 2;
    if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL b_single_strobe got %b exp 0", b_rd_valid); end
    if (b_rd_data !== 16'h1111) begin errors++; $display("FAIL b_hold_rd_data got %h exp 1111", b_rd_data); end
  endtask

  task automatic test_reset();
    int n;
    logic [14:0] ra [4];
    a_reset = 1'b1; repeat (3) tick();
    checks += 5;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL a_rst_busy got %b exp 1", a_busy); end
    if (a_req_ready !== 1'b0) begin errors++; $display("FAIL a_rst_ready got %b exp 0", a_req_ready); end
    if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL a_rst_rd_valid got %b exp 0", a_rd_valid); end
    if (a_rd_data !== 16'h0) begin errors++; $display("FAIL a_rst_rd_data got %h exp 0000", a_rd_data); end
    if (a_oor !== 1'b0) begin errors++; $display("FAIL a_rst_oor got %b exp 0", a_oor); end
    a_reset = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 20000) begin tick(); n++; end
    checks += 2;
    if (n != 16384) begin errors++; $display("FAIL a_clear_len got %0d exp 16384", n); end
    if (a_req_ready !== 1'b1) begin errors++; $display("FAIL a_ready_after_clear got %b exp 1", a_req_ready); end
    model_clear();
    ra[0] = 15'h0000; ra[1] = 15'h3FFF; ra[2] = 15'h4000; ra[3] = 15'h7FFF;
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b0, 2'b00, ra[i], 16'h0); tick();
      a_req_valid = 1'b0; tick();
      checks += 2;
      if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL a_clr_rd_valid addr %h got %b exp 1", ra[i], a_rd_valid); end
      if (a_rd_data !== 16'h0) begin errors++; $display("FAIL a_clr_rd_data addr %h got %h exp 0000", ra[i], a_rd_data); end
    end
  endtask

  task automatic test_back_to_back();
    a_drive(1'b1, 2'b11, 15'h0010, 16'hA5C3); tick();
    a_drive(1'b1, 2'b11, 15'h4010, 16'h1234); tick();
    a_drive(1'b0, 2'b00, 15'h0010, 16'h0); tick();
    checks++;
    if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got %b exp 0", a_rd_valid); end
    a_drive(1'b0, 2'b00, 15'h4010, 16'h0); tick();
    checks += 2;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %b exp 1", a_rd_valid); end
    if (a_rd_data !== 16'hA5C3) begin errors++; $display("FAIL b2b_data0 got %h exp a5c3", a_rd_data); end
    a_req_valid = 1'b0; tick();
    checks += 2;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", a_rd_valid); end
    if (a_rd_data !== 16'h1234) begin errors++; $display("FAIL b2b_data1 got %h exp 1234", a_rd_data); end
    tick();
    checks += 2;
    if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_strobe got %b exp 0", a_rd_valid); end
    if (a_rd_data !== 16'h1234) begin errors++; $display("FAIL b2b_hold got %h exp 1234", a_rd_data); end
  endtask

  task automatic test_byte_lanes();
    a_drive(1'b1, 2'b11, 15'h0020, 16'hFFFF); tick();
    a_drive(1'b1, 2'b01, 15'h0020, 16'h0012); tick();
    a_drive(1'b1, 2'b10, 15'h0020, 16'hAB00); tick();
    a_drive(1'b0, 2'b00, 15'h0020, 16'h0); tick();
    a_req_valid = 1'b0; tick();
    checks += 2;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL lanes_valid got %b exp 1", a_rd_valid); end
    if (a_rd_data !== 16'hAB12) begin errors++; $display("FAIL lanes_data got %h exp ab12", a_rd_data); end
    a_drive(1'b1, 2'b00, 15'h0020, 16'h0000); tick();
    a_drive(1'b0, 2'b00, 15'h0020, 16'h0); tick();
    a_req_valid = 1'b0; tick();
    checks++;
    if (a_rd_data !== 16'hAB12) begin errors++; $display("FAIL lanes_be00 got %h exp ab12", a_rd_data); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [14:0] pool [8];
    logic [14:0] addr;
    logic exp_v;
    int cyc = 0;
    for (int i = 0; i < 8; i++) pool[i] = 15'($urandom_range(0, 32767));
    for (int i = 0; i < 303; i++) begin
      if (i < 300 && $urandom_range(0, 3) != 0) begin
        addr = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) begin
          a_drive(1'b1, 2'($urandom_range(0, 3)), addr, 16'($urandom));
        end else begin
          a_drive(1'b0, 2'b00, addr, 16'h0);
          e.due = cyc + 2; e.d = ma[addr];
          q.push_back(e);
        end
      end else begin
        a_req_valid = 1'b0;
      end
      tick(); cyc++;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      checks++;
      if (a_rd_valid !== exp_v) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, a_rd_valid, exp_v); end
      if (exp_v) begin
        e = q.pop_front();
        checks++;
        if (a_rd_data !== e.d) begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", cyc, a_rd_data, e.d); end
      end
    end
    a_req_valid = 1'b0;
  endtask

  task automatic test_clear_order();
    int n;
    a_drive(1'b1, 2'b11, 15'h0010, 16'h5555); tick();
    a_drive(1'b0, 2'b00, 15'h0010, 16'h0); a_clear_req = 1'b1; tick();
    a_req_valid = 1'b0; a_clear_req = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_next got %b exp 1", a_busy); end
    n = 0;
    tick(); n++;
    checks += 2;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid got %b exp 1", a_rd_valid); end
    if (a_rd_data !== 16'h5555) begin errors++; $display("FAIL clr_pre_data got %h exp 5555", a_rd_data); end
    while (a_busy === 1'b1 && n < 20000) begin
      a_clear_req = (n == 50);
      tick(); n++;
    end
    a_clear_req = 1'b0;
    checks++;
    if (n != 16384) begin errors++; $display("FAIL clr_len got %0d exp 16384", n); end
    model_clear();
    a_drive(1'b0, 2'b00, 15'h0010, 16'h0); tick();
    a_req_valid = 1'b0; tick();
    checks += 2;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL clr_post_valid got %b exp 1", a_rd_valid); end
    if (a_rd_data !== ma[15'h0010]) begin errors++; $display("FAIL clr_post_data got %h exp %h", a_rd_data, ma[15'h0010]); end
  endtask

  task automatic test_reset_midflight();
    int n;
    int seen;
    a_clear_req = 1'b1; tick(); a_clear_req = 1'b0;
    repeat (100) tick();
    a_reset = 1'b1; tick();
    checks++;
    if (a_req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", a_req_ready); end
    a_reset = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 20000) begin tick(); n++; end
    checks++;
    if (n != 16384) begin errors++; $display("FAIL mid_clear_restart got %0d exp 16384", n); end
    a_drive(1'b1, 2'b11, 15'h0030, 16'h7777); tick();
    a_drive(1'b0, 2'b00, 15'h0030, 16'h0); tick();
    a_req_valid = 1'b0; a_reset = 1'b1; tick(); a_reset = 1'b0;
    n = 0; seen = 0;
    while (a_busy === 1'b1 && n < 20000) begin
      if (a_rd_valid === 1'b1) seen++;
      tick(); n++;
    end
    checks += 2;
    if (seen != 0) begin errors++; $display("FAIL flush_rd_valid got %0d strobes exp 0", seen); end
    if (n != 16384) begin errors++; $display("FAIL flush_clear_len got %0d exp 16384", n); end
    model_clear();
    a_drive(1'b0, 2'b00, 15'h0030, 16'h0); tick();
    a_req_valid = 1'b0; tick();
    checks++;
    if (a_rd_data !== ma[15'h0030]) begin errors++; $display("FAIL flush_post_data got %h exp %h", a_rd_data, ma[15'h0030]); end
  endtask

  initial begin
    a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_be = '0; a_req_addr = '0;
    a_req_wdata = '0; a_clear_req = 1'b0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = '0; b_req_addr = '0;
    b_req_wdata = '0; b_clear_req = 1'b0;
    model_clear();
    tick(); tick();
    test_oor();
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_random();
    test_clear_order();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
